// File: rtl/uno_cpu_player.sv
// Computer opponent for the UNO game FSM: per-slot hand counts, priority card scan, draw/play handshakes.
// Optional draw-two stacking is enabled by defining CPU_STACK_EN.
module uno_cpu_player #(
  parameter int         N_COLOR   = 4,
  parameter int         N_VAL     = 13,
  parameter int         CNT_W     = 2,
  parameter int         INIT_HAND = 7,
  parameter int         V_DRAW2   = 12,
  parameter logic [3:0] LFSR_SEED = 4'b0110
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_init,
  input  logic       i_start,
  input  logic [5:0] i_prev_card,
  input  logic       i_draw_two,
  input  logic       i_draw_four,
  output logic       o_draw_req,
  input  logic       i_draw_valid,
  input  logic [5:0] i_draw_card,
  output logic       o_out_valid,
  output logic [5:0] o_out_card,
  input  logic       i_out_ack,
  output logic       o_done,
  output logic [7:0] o_hand_cnt,
  output logic       o_uno,
  output logic       o_err
);

`ifdef CPU_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  localparam logic [3:0]       V_WILD  = 4'd13;
  localparam logic [3:0]       V_WILD4 = 4'd14;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_DRAW, S_SCAN_COL, S_SCAN_NUM, S_SCAN_WILD, S_CHOOSE, S_DRAW1, S_CHECK, S_OFFER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hand [N_COLOR][N_VAL];
  logic [CNT_W-1:0] wild_cnt, wild4_cnt;
  logic [3:0]       lfsr, rem, idx, k;
  logic [1:0]       c;
  logic [5:0]       prev, drawn;

  logic       xfer, ack, in_bad, in_full, stack_hit, prev_col_empty;
  logic [3:0] in_val;
  logic [1:0] in_col, best_col, stack_col;
  logic [7:0] col_tot [N_COLOR];

  assign xfer   = o_draw_req & i_draw_valid;
  assign ack    = o_out_valid & i_out_ack;
  assign in_val = i_draw_card[3:0];
  assign in_col = i_draw_card[5:4];
  assign o_uno  = (o_hand_cnt == 8'd1);

  always_comb begin
    in_bad    = (in_val > V_WILD4) ||
                (in_val < V_WILD && (int'(in_val) >= N_VAL || int'(in_col) >= N_COLOR));
    in_full   = 1'b0;
    if (in_val == V_WILD)       in_full = (wild_cnt == CNT_MAX);
    else if (in_val == V_WILD4) in_full = (wild4_cnt == CNT_MAX);
    else if (!in_bad)           in_full = (hand[in_col][in_val] == CNT_MAX);

    best_col  = '0;
    stack_hit = 1'b0;
    stack_col = '0;
    for (int ci = 0; ci < N_COLOR; ci++) begin
      col_tot[ci] = '0;
      for (int vi = 0; vi < N_VAL; vi++) col_tot[ci] = col_tot[ci] + 8'(hand[ci][vi]);
    end
    // Strict compare keeps ties (and the empty hand) on the lowest colour index.
    for (int ci = 1; ci < N_COLOR; ci++)
      if (col_tot[ci] > col_tot[best_col]) best_col = 2'(ci);
    for (int ci = N_COLOR - 1; ci >= 0; ci--)
      if (hand[ci][V_DRAW2] != '0) begin
        stack_hit = 1'b1;
        stack_col = 2'(ci);
      end
    prev_col_empty = (int'(i_prev_card[5:4]) >= N_COLOR) || (col_tot[i_prev_card[5:4]] == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      rem         <= '0;
      idx         <= '0;
      k           <= '0;
      c           <= '0;
      prev        <= '0;
      drawn       <= '0;
      o_draw_req  <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_card  <= '0;
      o_done      <= 1'b0;
      o_hand_cnt  <= '0;
      o_err       <= 1'b0;
      wild_cnt    <= '0;
      wild4_cnt   <= '0;
      // NOTE: the hand is a small register array, not a RAM, so it is cleared by reset like any flop.
      for (int ci = 0; ci < N_COLOR; ci++)
        for (int vi = 0; vi < N_VAL; vi++) hand[ci][vi] <= '0;
    end else begin
      lfsr   <= {lfsr[0] ^ lfsr[1], lfsr[3:1]};
      o_done <= 1'b0;

      if (xfer) begin
        if (in_bad || in_full) o_err <= 1'b1;
        else begin
          o_hand_cnt <= o_hand_cnt + 8'd1;
          if (in_val == V_WILD)       wild_cnt  <= wild_cnt + 1'b1;
          else if (in_val == V_WILD4) wild4_cnt <= wild4_cnt + 1'b1;
          else                        hand[in_col][in_val] <= hand[in_col][in_val] + 1'b1;
        end
      end
      if (ack) begin
        o_hand_cnt <= o_hand_cnt - 8'd1;
        if (o_out_card[3:0] == V_WILD)       wild_cnt  <= wild_cnt - 1'b1;
        else if (o_out_card[3:0] == V_WILD4) wild4_cnt <= wild4_cnt - 1'b1;
        else hand[o_out_card[5:4]][o_out_card[3:0]] <= hand[o_out_card[5:4]][o_out_card[3:0]] - 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (i_init) begin
            for (int ci = 0; ci < N_COLOR; ci++)
              for (int vi = 0; vi < N_VAL; vi++) hand[ci][vi] <= '0;
            wild_cnt   <= '0;
            wild4_cnt  <= '0;
            o_hand_cnt <= '0;
            rem        <= 4'(INIT_HAND);
            o_draw_req <= 1'b1;
            state      <= S_DRAW;
          end else if (i_start) begin
            prev <= i_prev_card;
            k    <= '0;
            c    <= '0;
            idx  <= 4'(lfsr % N_VAL);
            if (i_draw_four) begin
              rem <= 4'd4; o_draw_req <= 1'b1; state <= S_DRAW;
            end else if (STACK_EN && i_draw_two && stack_hit) begin
              o_out_card  <= {stack_col, 4'(V_DRAW2)};
              o_out_valid <= 1'b1;
              state       <= S_OFFER;
            end else if (i_draw_two) begin
              rem <= 4'd2; o_draw_req <= 1'b1; state <= S_DRAW;
            end else if (i_prev_card[3:0] >= V_WILD && prev_col_empty) begin
              state <= (int'(i_prev_card[3:0]) >= N_VAL) ? S_SCAN_WILD : S_SCAN_NUM;
            end else begin
              state <= S_SCAN_COL;
            end
          end
        end
        S_DRAW: if (xfer) begin
          if (rem == 4'd1) begin
            o_draw_req <= 1'b0; o_done <= 1'b1; state <= S_IDLE;
          end else rem <= rem - 4'd1;
        end
        S_SCAN_COL: begin
          if (int'(prev[5:4]) < N_COLOR && hand[prev[5:4]][idx] != '0) begin
            o_out_card <= {prev[5:4], idx}; o_out_valid <= 1'b1; state <= S_OFFER;
          end else if (k == 4'(N_VAL - 1)) begin
            state <= (int'(prev[3:0]) >= N_VAL) ? S_SCAN_WILD : S_SCAN_NUM;
          end else begin
            k   <= k + 4'd1;
            idx <= (idx == 4'(N_VAL - 1)) ? 4'd0 : idx + 4'd1;
          end
        end
        S_SCAN_NUM: begin
          if (hand[c][prev[3:0]] != '0) begin
            o_out_card <= {c, prev[3:0]}; o_out_valid <= 1'b1; state <= S_OFFER;
          end else if (c == 2'(N_COLOR - 1)) state <= S_SCAN_WILD;
          else c <= c + 2'd1;
        end
        S_SCAN_WILD: begin
          if (wild_cnt != '0)       begin o_out_card <= {2'b00, V_WILD};  state <= S_CHOOSE; end
          else if (wild4_cnt != '0) begin o_out_card <= {2'b00, V_WILD4}; state <= S_CHOOSE; end
          else                      begin o_draw_req <= 1'b1;             state <= S_DRAW1;  end
        end
        S_CHOOSE: begin
          o_out_card[5:4] <= best_col; o_out_valid <= 1'b1; state <= S_OFFER;
        end
        S_DRAW1: if (xfer) begin
          drawn <= i_draw_card; o_draw_req <= 1'b0; state <= S_CHECK;
        end
        S_CHECK: begin
          if (drawn[3:0] == V_WILD || drawn[3:0] == V_WILD4) begin
            o_out_card <= {2'b00, drawn[3:0]}; state <= S_CHOOSE;
          end else if (int'(drawn[3:0]) < N_VAL && int'(drawn[5:4]) < N_COLOR &&
                       (drawn[5:4] == prev[5:4] || drawn[3:0] == prev[3:0])) begin
            o_out_card <= drawn; o_out_valid <= 1'b1; state <= S_OFFER;
          end else begin
            o_done <= 1'b1; state <= S_IDLE;
          end
        end
        S_OFFER: if (ack) begin
          o_out_valid <= 1'b0; o_done <= 1'b1; state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uno_cpu_player.sv
// Directed scoreboard bench for uno_cpu_player: expected offers are queued at turn start and compared at turn end.
module tb_uno_cpu_player;

  logic       i_clk = 1'b0, i_rst_n = 1'b0;
  logic       i_init = 1'b0, i_start = 1'b0, i_draw_two = 1'b0, i_draw_four = 1'b0;
  logic [5:0] i_prev_card = '0, i_draw_card = '0;
  logic       i_draw_valid = 1'b0, i_out_ack = 1'b0;
  logic       o_draw_req, o_out_valid, o_done, o_uno, o_err;
  logic [5:0] o_out_card;
  logic [7:0] o_hand_cnt;

  always #5 i_clk = ~i_clk;

  uno_cpu_player dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_init(i_init), .i_start(i_start),
    .i_prev_card(i_prev_card), .i_draw_two(i_draw_two), .i_draw_four(i_draw_four),
    .o_draw_req(o_draw_req), .i_draw_valid(i_draw_valid), .i_draw_card(i_draw_card),
    .o_out_valid(o_out_valid), .o_out_card(o_out_card), .i_out_ack(i_out_ack),
    .o_done(o_done), .o_hand_cnt(o_hand_cnt), .o_uno(o_uno), .o_err(o_err)
  );

  typedef struct { bit offer; logic [5:0] card; } exp_t;
  exp_t       sb_q[$];
  logic [5:0] deck_q[$];

  int checks = 0, failures = 0;
  int n_xfer, n_req, n_valid, lat;
  bit got_done, got_offer, stable_ok, done_seen;
  logic [5:0] offer_card;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Drives one turn (init or start) and plays deck and discard pile until o_done or the budget runs out.
  task automatic turn(input bit init, input logic [5:0] prev, input bit d2, input bit d4,
                      input int ack_delay, input bit gap);
    n_xfer = 0; n_req = 0; n_valid = 0; lat = 0;
    got_done = 0; got_offer = 0; stable_ok = 1; offer_card = '0;
    @(negedge i_clk);
    i_init = init; i_start = !init; i_prev_card = prev; i_draw_two = d2; i_draw_four = d4;
    i_draw_valid = 1'b0; i_out_ack = 1'b0;
    for (int cyc = 1; cyc <= 200 && !got_done; cyc++) begin
      @(negedge i_clk);
      i_init = 1'b0; i_start = 1'b0; i_draw_two = 1'b0; i_draw_four = 1'b0;
      if (o_done) got_done = 1;
      if (o_draw_req) n_req++;
      if (o_out_valid) begin
        if (!got_offer) begin got_offer = 1; offer_card = o_out_card; lat = cyc; end
        else if (o_out_card !== offer_card) stable_ok = 0;
        n_valid++;
      end
      i_draw_valid = (deck_q.size() > 0) && (!gap || cyc[0]);
      i_draw_card  = (deck_q.size() > 0) ? deck_q[0] : 6'h00;
      if (o_draw_req && i_draw_valid) begin
        void'(deck_q.pop_front());
        n_xfer++;
      end
      i_out_ack = o_out_valid && (n_valid >= ack_delay);
    end
    i_draw_valid = 1'b0; i_out_ack = 1'b0;
    check("turn_done_seen", 32'(got_done), 1);
  endtask

  task automatic score();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty: observed=0 entries expected=1");
      return;
    end
    e = sb_q.pop_front();
    check("offer_flag", 32'(got_offer), 32'(e.offer));
    if (e.offer) begin
      check("offer_card", 32'(offer_card), 32'(e.card));
      check("offer_stable", 32'(stable_ok), 1);
    end
    @(negedge i_clk);
    check("done_one_cycle", 32'(o_done), 0);
  endtask

  // Reset, then i_init with n real cards padded by illegal code 0x0F to INIT_HAND.
  task automatic load_hand(input logic [5:0] c0, input logic [5:0] c1, input logic [5:0] c2,
                           input logic [5:0] c3, input int n);
    logic [5:0] cs [4];
    cs = '{c0, c1, c2, c3};
    do_reset();
    deck_q.delete();
    for (int i = 0; i < 7; i++) deck_q.push_back(i < n ? cs[i] : 6'h0F);
    sb_q.push_back('{1'b0, 6'h00});
    turn(1'b1, 6'h00, 1'b0, 1'b0, 1, 1'b0);
    score();
    check("load_hand_cnt", 32'(o_hand_cnt), 32'(n));
  endtask

  initial begin
    do_reset();
    @(negedge i_clk);
    check("rst_hand_cnt", 32'(o_hand_cnt), 0);
    check("rst_err", 32'(o_err), 0);
    check("rst_outputs", {28'd0, o_draw_req, o_out_valid, o_done, o_uno}, 0);

    // Init with a saturating slot, wild, wild-four.
    deck_q = '{6'h03, 6'h03, 6'h03, 6'h03, 6'h1D, 6'h2E, 6'h35};
    sb_q.push_back('{1'b0, 6'h00});
    turn(1'b1, 6'h00, 1'b0, 1'b0, 1, 1'b0);
    check("init_xfers", 32'(n_xfer), 7);
    check("init_hand_cnt", 32'(o_hand_cnt), 6);
    check("init_err", 32'(o_err), 1);
    score();

    // Colour match with a slow discard pile.
    load_hand(6'h15, 6'h22, 6'h00, 6'h00, 2);
    sb_q.push_back('{1'b1, 6'h15});
    turn(1'b0, 6'h17, 1'b0, 1'b0, 3, 1'b0);
    check("col_valid_cycles", 32'(n_valid), 3);
    check("col_hand_cnt", 32'(o_hand_cnt), 1);
    check("col_uno", 32'(o_uno), 1);
    score();

    // Number match.
    load_hand(6'h27, 6'h34, 6'h00, 6'h00, 2);
    sb_q.push_back('{1'b1, 6'h27});
    turn(1'b0, 6'h07, 1'b0, 1'b0, 1, 1'b0);
    check("num_hand_cnt", 32'(o_hand_cnt), 1);
    score();

    // Wild: full scan, blue holds most cards.
    load_hand(6'h0D, 6'h31, 6'h32, 6'h15, 4);
    sb_q.push_back('{1'b1, 6'h3D});
    turn(1'b0, 6'h29, 1'b0, 1'b0, 1, 1'b0);
    check("wild_latency", 32'(lat), 20);
    check("wild_hand_cnt", 32'(o_hand_cnt), 3);
    score();

    // Draw one card and play it.
    load_hand(6'h11, 6'h00, 6'h00, 6'h00, 1);
    deck_q = '{6'h08};
    sb_q.push_back('{1'b1, 6'h08});
    turn(1'b0, 6'h05, 1'b0, 1'b0, 1, 1'b0);
    check("dp_req_cycles", 32'(n_req), 1);
    check("dp_hand_cnt", 32'(o_hand_cnt), 1);
    score();

    // Draw one unplayable card.
    load_hand(6'h11, 6'h00, 6'h00, 6'h00, 1);
    deck_q = '{6'h39};
    sb_q.push_back('{1'b0, 6'h00});
    turn(1'b0, 6'h05, 1'b0, 1'b0, 1, 1'b0);
    check("dn_xfers", 32'(n_xfer), 1);
    check("dn_hand_cnt", 32'(o_hand_cnt), 2);
    score();

    // Draw-two penalty with a gappy deck.
    load_hand(6'h2C, 6'h00, 6'h00, 6'h00, 1);
    deck_q = '{6'h01, 6'h02};
`ifdef CPU_STACK_EN
    sb_q.push_back('{1'b1, 6'h2C});
    turn(1'b0, 6'h1C, 1'b1, 1'b0, 1, 1'b1);
    check("stack_req_cycles", 32'(n_req), 0);
    check("stack_hand_cnt", 32'(o_hand_cnt), 0);
`else
    sb_q.push_back('{1'b0, 6'h00});
    turn(1'b0, 6'h1C, 1'b1, 1'b0, 1, 1'b1);
    check("d2_xfers", 32'(n_xfer), 2);
    check("d2_hand_cnt", 32'(o_hand_cnt), 3);
`endif
    score();

    // Draw-four is always drawn.
    load_hand(6'h2C, 6'h00, 6'h00, 6'h00, 1);
    deck_q = '{6'h01, 6'h02, 6'h13, 6'h24};
    sb_q.push_back('{1'b0, 6'h00});
    turn(1'b0, 6'h1E, 1'b0, 1'b1, 1, 1'b0);
    check("d4_xfers", 32'(n_xfer), 4);
    check("d4_hand_cnt", 32'(o_hand_cnt), 5);
    score();

    // Asynchronous reset in the middle of init aborts without o_done.
    do_reset();
    deck_q.delete();
    @(negedge i_clk); i_init = 1'b1;
    @(negedge i_clk); i_init = 1'b0; i_draw_valid = 1'b1; i_draw_card = 6'h01;
    @(negedge i_clk);
    check("abort_pre_cnt", 32'(o_hand_cnt), 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("abort_req", 32'(o_draw_req), 0);
    check("abort_hand_cnt", 32'(o_hand_cnt), 0);
    i_draw_valid = 1'b0;
    @(negedge i_clk); i_rst_n = 1'b1;
    done_seen = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_done) done_seen = 1;
    end
    check("abort_no_done", 32'(done_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
